// File: rtl/shift_pow2_pkg.sv
// Shared definitions for the power-of-two shift/divide pipeline.
// The operation encoding travels with every beat through the stages.
package shift_pow2_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    SHIFT_LOGICAL   = 2'd0,
    SHIFT_ARITH     = 2'd1,
    SHIFT_DIV_TRUNC = 2'd2,
    SHIFT_ROTATE    = 2'd3
  } shift_mode_e;

endpackage

// File: rtl/shift_pow2_stage.sv
// One pipeline stage: optionally shifts right by AMT and registers the beat
// together with its mode, shift amount and inexact flag.
module shift_pow2_stage
  import shift_pow2_pkg::*;
#(
  parameter int N   = 8,
  parameter int AMT = 1,
  localparam int SW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  input  shift_mode_e      in_mode,
  input  logic [SW-1:0]    in_shift,
  input  logic             in_inexact,
  output logic             out_valid,
  output logic [N-1:0]     out_data,
  output shift_mode_e      out_mode,
  output logic [SW-1:0]    out_shift,
  output logic             out_inexact
);

  localparam int BIT = $clog2(AMT);

  logic            valid_q, valid_d;
  logic [N-1:0]    data_q, data_d;
  shift_mode_e     mode_q, mode_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic            inexact_q, inexact_d;
  logic [N-1:0]    shifted;

  // Arithmetic fill uses the current MSB; for the divide mode this is the
  // sign of the biased operand, which is what truncation toward zero needs.
  always_comb begin
    shifted = in_data;
    case (in_mode)
      SHIFT_LOGICAL:               shifted = in_data >> AMT;
      SHIFT_ARITH, SHIFT_DIV_TRUNC: shifted = $signed(in_data) >>> AMT;
      default:                     shifted = {in_data[AMT-1:0], in_data[N-1:AMT]};
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    mode_d    = mode_q;
    shift_d   = shift_q;
    inexact_d = inexact_q;
    if (load) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d    = in_shift[BIT] ? shifted : in_data;
        mode_d    = in_mode;
        shift_d   = in_shift;
        inexact_d = in_inexact;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      mode_q    <= SHIFT_LOGICAL;
      shift_q   <= '0;
      inexact_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      mode_q    <= mode_d;
      shift_q   <= shift_d;
      inexact_q <= inexact_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_mode    = mode_q;
  assign out_shift   = shift_q;
  assign out_inexact = inexact_q;

endmodule

// File: rtl/shift_divide_pow2_pipe.sv
// Pipelined right shifter / signed power-of-two divider with valid/ready
// handshakes; stage k conditionally shifts by 2**k.
module shift_divide_pow2_pipe
  import shift_pow2_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_data,
  input  logic [SW-1:0]     in_shift,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data,
  output logic              out_inexact
);

  logic [N-1:0]  stg_data    [SW];
  logic          stg_valid   [SW];
  shift_mode_e   stg_mode    [SW];
  logic [SW-1:0] stg_shift   [SW];
  logic          stg_inexact [SW];

  logic [N-1:0]  s0_data;
  logic          s0_inexact;
  shift_mode_e   s0_mode;
  logic [N-1:0]  bias_mask;
  logic [SW-1:0] load_v;
  logic          adv;

  // Negative operands in divide mode get 2**s-1 added so the arithmetic
  // shift rounds toward zero; the sum stays within N-bit signed range.
  always_comb begin
    s0_mode    = shift_mode_e'(in_mode);
    bias_mask  = (N'(1) << in_shift) - N'(1);
    s0_inexact = |(in_data & bias_mask);
    s0_data    = in_data;
    if (s0_mode == SHIFT_DIV_TRUNC && in_data[N-1])
      s0_data = in_data + bias_mask;
  end

  // A stage may load when it is empty or its successor is taking its beat.
  always_comb begin
    adv    = out_ready;
    load_v = '0;
    for (int i = SW - 1; i >= 0; i--) begin
      adv       = ~stg_valid[i] | adv;
      load_v[i] = adv;
    end
  end

  assign in_ready = load_v[0] & ~rst;

  for (genvar gi = 0; gi < SW; gi++) begin : g_stage
    logic [N-1:0]  d_in;
    logic          v_in;
    shift_mode_e   m_in;
    logic [SW-1:0] s_in;
    logic          x_in;

    if (gi == 0) begin : g_first
      assign d_in = s0_data;
      assign v_in = in_valid;
      assign m_in = s0_mode;
      assign s_in = in_shift;
      assign x_in = s0_inexact;
    end else begin : g_next
      assign d_in = stg_data[gi-1];
      assign v_in = stg_valid[gi-1];
      assign m_in = stg_mode[gi-1];
      assign s_in = stg_shift[gi-1];
      assign x_in = stg_inexact[gi-1];
    end

    shift_pow2_stage #(
      .N   (N),
      .AMT (2 ** gi)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .load        (load_v[gi]),
      .in_valid    (v_in),
      .in_data     (d_in),
      .in_mode     (m_in),
      .in_shift    (s_in),
      .in_inexact  (x_in),
      .out_valid   (stg_valid[gi]),
      .out_data    (stg_data[gi]),
      .out_mode    (stg_mode[gi]),
      .out_shift   (stg_shift[gi]),
      .out_inexact (stg_inexact[gi])
    );
  end

  assign out_valid   = stg_valid[SW-1] & ~rst;
  assign out_data    = rst ? '0 : stg_data[SW-1];
  assign out_inexact = rst ? 1'b0 : stg_inexact[SW-1];

  logic unused_tail;
  assign unused_tail = ^{stg_shift[SW-1], stg_mode[SW-1]};

endmodule

// File: tb/tb_shift_divide_pow2_pipe.sv
// Scoreboard bench for shift_divide_pow2_pipe at N=8: directed vectors,
// random traffic with backpressure, stall capacity and mid-flight reset.
module tb_shift_divide_pow2_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_shift;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_inexact;

  shift_divide_pow2_pipe #(.N(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_shift    (in_shift),
    .in_mode     (in_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_inexact (out_inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       inx;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic       acc_flag = 1'b0;
  logic       last_in_ready;
  logic       chk_lat  = 1'b0;
  logic [7:0] exp_data;
  logic       exp_inx;

  // Directed vectors with hand-derived expectations.
  logic [7:0] dir_a [11] = '{8'hEB, 8'hEB, 8'hEB, 8'hEB, 8'h80, 8'h80, 8'h80,
                              8'h5A, 8'h5A, 8'h5A, 8'h5A};
  logic [2:0] dir_s [11] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd7, 3'd7, 3'd7,
                              3'd0, 3'd0, 3'd0, 3'd0};
  logic [1:0] dir_m [11] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2,
                              2'd0, 2'd1, 2'd2, 2'd3};
  logic [7:0] dir_e [11] = '{8'h1D, 8'hFD, 8'hFE, 8'h7D, 8'h01, 8'hFF, 8'hFF,
                              8'h5A, 8'h5A, 8'h5A, 8'h5A};
  logic       dir_x [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] a, input int s, input int m);
    logic signed [7:0] sa;
    logic [15:0]       dd;
    int                q;
    logic [7:0]        r;
    sa = a;
    case (m)
      0: r = a >> s;
      1: r = sa >>> s;
      2: begin
        q = int'(sa) / (1 << s);
        r = q[7:0];
      end
      default: begin
        dd = {a, a} >> s;
        r  = dd[7:0];
      end
    endcase
    return r;
  endfunction

  function automatic logic model_inx(input logic [7:0] a, input int s);
    logic [7:0] mask;
    mask = 8'((1 << s) - 1);
    return (a & mask) != 8'h00;
  endfunction

  task automatic settle();
    #1;
  endtask

  // Evaluates this cycle's handshakes (inputs settled), then advances to the next negedge.
  task automatic step();
    exp_t e;
    acc_flag      = in_valid && in_ready;
    last_in_ready = in_ready;
    if (out_valid && sb.size() == 0)
      check_eq("spurious_out_valid", out_valid, 0);
    if (out_valid && !out_ready && sb.size() != 0)
      check_eq("hold_data", out_data, sb[0].data);
    if (out_valid && out_ready && sb.size() != 0) begin
      e = sb.pop_front();
      $display("beat out: data=%02h inexact=%0d exp=%02h/%0d", out_data, out_inexact, e.data, e.inx);
      check_eq("data", out_data, e.data);
      check_eq("inexact", out_inexact, e.inx);
      if (chk_lat) check_eq("latency", cyc - e.cyc, 3);
    end
    if (acc_flag) sb.push_back('{exp_data, exp_inx, cyc});
    @(negedge clk);
    cyc++;
  endtask

  task automatic tick();
    settle();
    step();
  endtask

  task automatic send(input logic [7:0] a, input logic [2:0] s, input logic [1:0] m,
                      input logic [7:0] ed, input logic ei);
    in_valid = 1'b1;
    in_data  = a;
    in_shift = s;
    in_mode  = m;
    exp_data = ed;
    exp_inx  = ei;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (acc_flag) break;
    end
    if (!acc_flag) check_eq("accept_timeout", acc_flag, 1);
    in_valid = 1'b0;
  endtask

  task automatic new_beat();
    in_data  = 8'($urandom);
    in_shift = 3'($urandom_range(0, 7));
    in_mode  = 2'($urandom_range(0, 3));
    exp_data = model(in_data, int'(in_shift), int'(in_mode));
    exp_inx  = model_inx(in_data, int'(in_shift));
  endtask

  task automatic send_rand();
    new_beat();
    send(in_data, in_shift, in_mode, exp_data, exp_inx);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int k = 0; k < 60 && sb.size() != 0; k++) tick();
    check_eq("drained", sb.size(), 0);
  endtask

  initial begin
    int sent;
    int n_acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shift  = '0;
    in_mode   = '0;
    out_ready = 1'b1;
    exp_data  = '0;
    exp_inx   = 1'b0;
    @(negedge clk);

    // Reset state
    for (int k = 0; k < 2; k++) begin
      settle();
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_out_data", out_data, 0);
      check_eq("rst_out_inexact", out_inexact, 0);
      step();
    end
    rst = 1'b0;
    settle();
    check_eq("post_rst_in_ready", in_ready, 1);
    step();

    // Directed vectors back-to-back with latency checking
    chk_lat = 1'b1;
    for (int i = 0; i < 11; i++) send(dir_a[i], dir_s[i], dir_m[i], dir_e[i], dir_x[i]);
    drain();
    chk_lat = 1'b0;

    // Random traffic with random backpressure
    sent = 0;
    acc_flag = 1'b0;
    for (int g = 0; g < 20000 && sent < 1000; g++) begin
      if (!in_valid || acc_flag) begin
        new_beat();
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (acc_flag) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check_eq("rand_sent", sent, 1000);

    // Stall capacity: pipeline holds exactly three beats
    out_ready = 1'b0;
    acc_flag  = 1'b0;
    n_acc     = 0;
    in_valid  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!in_valid || acc_flag) new_beat();
      in_valid = 1'b1;
      tick();
      if (acc_flag) n_acc++;
    end
    check_eq("stall_accepts", n_acc, 3);
    check_eq("stall_in_ready", last_in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    settle();
    check_eq("ready_on_drain", in_ready, 1);
    step();
    drain();

    // Reset with three beats in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_rand();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    settle();
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 0);
    check_eq("midrst_out_data", out_data, 0);
    step();
    sb.delete();
    rst = 1'b0;
    settle();
    check_eq("midrst_release_ready", in_ready, 1);
    check_eq("midrst_release_valid", out_valid, 0);
    step();
    tick();
    tick();
    chk_lat = 1'b1;
    send(8'hEB, 3'd3, 2'd1, 8'hFD, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
